// File: rtl/pipe_stage_chain.sv
// Elastic pipeline register chain: valid/ready flow control, bubble compaction,
// synchronous flush and a registered occupancy count. Empty output reads as NOP (all zero).
module pipe_stage_chain #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int CNT_W  = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] occupancy
);

  logic [STAGES-1:0] v_q, v_d;
  logic [WIDTH-1:0]  d_q [STAGES];
  logic [WIDTH-1:0]  d_d [STAGES];
  logic [STAGES:0]   adv;
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic              in_xfer, out_xfer;

  // adv[k] = ~v[k] | adv[k+1] unrolled: a stage advances when out_ready is high
  // or any stage at or beyond it is empty. Avoids a self-referencing vector.
  always_comb begin
    logic tail_full;
    tail_full   = 1'b1;
    adv         = '0;
    adv[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      tail_full = tail_full & v_q[k];
      adv[k]    = out_ready | ~tail_full;
    end
  end

  assign in_ready  = adv[0] & ~flush;
  assign in_xfer   = in_valid & in_ready;
  assign out_valid = v_q[STAGES-1];
  assign out_xfer  = out_valid & out_ready;
  assign out_data  = v_q[STAGES-1] ? d_q[STAGES-1] : {WIDTH{1'b0}};
  assign occupancy = occ_q;

  always_comb begin
    v_d = v_q;
    for (int k = 0; k < STAGES; k++) d_d[k] = d_q[k];
    if (adv[0]) begin
      v_d[0] = in_valid;
      d_d[0] = in_data;
    end
    for (int k = 1; k < STAGES; k++) begin
      if (adv[k]) begin
        v_d[k] = v_q[k-1];
        d_d[k] = d_q[k-1];
      end
    end
    // Data words may load during a flush; they stay hidden behind the cleared valids.
    if (flush) v_d = '0;
  end

  always_comb begin
    occ_d = occ_q;
    if (flush)                    occ_d = '0;
    else if (in_xfer && !out_xfer) occ_d = occ_q + CNT_W'(1);
    else if (!in_xfer && out_xfer) occ_d = occ_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q   <= '0;
      occ_q <= '0;
      for (int k = 0; k < STAGES; k++) d_q[k] <= '0;
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
      for (int k = 0; k < STAGES; k++) d_q[k] <= d_d[k];
    end
  end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: a three-stage chain checked against a queue-with-positions
// model every cycle, plus a single-stage instance exercised directly.
module tb_pipe_stage_chain;
  localparam int W  = 32;
  localparam int S  = 3;
  localparam int CW = $clog2(S + 1);

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  in_data, out_data;
  logic [CW-1:0] occupancy;

  logic          flush1, in_valid1, in_ready1, out_valid1, out_ready1;
  logic [7:0]    in_data1, out_data1;
  logic [0:0]    occ1;

  int n_cmp = 0;
  int n_err = 0;

  // Model: oldest entry first; m_pos is its slot index (0 = input side).
  logic [W-1:0] m_data[$];
  int           m_pos[$];
  int           plan_pos[$];
  bit           plan_rdy;
  logic [W-1:0] got[$];

  pipe_stage_chain #(.WIDTH(W), .STAGES(S)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipe_stage_chain #(.WIDTH(8), .STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .occupancy(occ1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // An entry moves one slot forward when that slot is free after the older entry
  // has made its own move; slot S means "handed downstream" and is free only with out_ready.
  task automatic model_plan(input bit o_rdy, input bit fl);
    int prev;
    plan_pos.delete();
    prev = -1;
    foreach (m_pos[i]) begin
      int t;
      t = m_pos[i] + 1;
      if ((t == S && !o_rdy) || prev == t) t = m_pos[i];
      plan_pos.push_back(t);
      prev = t;
    end
    plan_rdy = !fl && (plan_pos.size() == 0 || plan_pos[plan_pos.size()-1] > 0);
  endtask

  task automatic step(input bit iv, input logic [W-1:0] id, input bit o_rdy, input bit fl,
                      output bit acc);
    bit exp_v;
    @(negedge clk);
    in_valid = iv; in_data = id; out_ready = o_rdy; flush = fl;
    #1;
    model_plan(o_rdy, fl);
    exp_v = (m_pos.size() > 0) && (m_pos[0] == S - 1);
    chk("in_ready", in_ready, plan_rdy);
    chk("occupancy", occupancy, m_pos.size());
    chk("out_valid", out_valid, exp_v);
    chk("out_data", out_data, exp_v ? m_data[0] : '0);
    if (out_valid && o_rdy) got.push_back(out_data);
    acc = iv && plan_rdy;
    @(posedge clk);
    if (fl) begin
      m_pos.delete();
      m_data.delete();
    end else begin
      m_pos = plan_pos;
      if (m_pos.size() > 0 && m_pos[0] == S) begin
        void'(m_pos.pop_front());
        void'(m_data.pop_front());
      end
      if (acc) begin
        m_pos.push_back(0);
        m_data.push_back(id);
      end
    end
    #1;
  endtask

  initial begin
    bit acc;
    int idx;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    flush1 = 1'b0; in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_occ", occupancy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_occ1", occ1, 0);
    @(negedge clk);
    rst = 1'b1;

    // Streaming with out_ready held high.
    step(1, 32'h11, 1, 0, acc);
    step(1, 32'h22, 1, 0, acc);
    step(1, 32'h33, 1, 0, acc);
    chk("stream_first", out_data, 32'h11);
    chk("stream_peak", occupancy, 3);
    step(0, 0, 1, 0, acc);
    chk("stream_second", out_data, 32'h22);
    step(0, 0, 1, 0, acc);
    chk("stream_third", out_data, 32'h33);
    step(0, 0, 1, 0, acc);
    chk("stream_empty", out_valid, 0);

    // Back-pressure: only three of five offers fit.
    got.delete();
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      step(1, 32'hA0 + idx, 0, 0, acc);
      if (acc) idx++;
    end
    chk("bp_accepted", idx, 3);
    chk("bp_occ", occupancy, 3);
    chk("bp_hold", out_data, 32'hA0);
    chk("bp_in_ready", in_ready, 0);
    for (int c = 0; c < 12; c++) begin
      step(idx < 5, 32'hA0 + idx, 1, 0, acc);
      if (acc) idx++;
    end
    chk("bp_count", got.size(), 5);
    for (int i = 0; i < 5; i++) chk("bp_order", (i < got.size()) ? got[i] : 'x, 32'hA0 + i);

    // Bubble compaction under stall.
    step(1, 32'h5, 0, 0, acc);
    step(0, 0, 0, 0, acc);
    step(1, 32'h6, 0, 0, acc);
    step(0, 0, 0, 0, acc);
    step(0, 0, 0, 0, acc);
    chk("bubble_occ", occupancy, 2);
    chk("bubble_out", out_data, 32'h5);
    step(1, 32'h7, 0, 0, acc);
    chk("bubble_third_acc", acc, 1);
    chk("bubble_full", occupancy, 3);

    // Flush with an input offered in the same cycle.
    step(0, 0, 1, 0, acc);
    chk("pre_flush_occ", occupancy, 2);
    step(1, 32'h77, 0, 1, acc);
    chk("flush_in_ready", in_ready, 0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_out_data", out_data, 0);
    chk("flush_occ", occupancy, 0);
    got.delete();
    repeat (4) step(0, 0, 1, 0, acc);
    chk("flush_no_leak", got.size(), 0);

    // Asynchronous reset mid-stream.
    step(1, 32'h41, 0, 0, acc);
    step(1, 32'h42, 0, 0, acc);
    chk("pre_rst_occ", occupancy, 2);
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b0; out_ready = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_occ", occupancy, 0);
    m_pos.delete(); m_data.delete();
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Randomized traffic with occasional flush.
    for (int c = 0; c < 400; c++) begin
      step(bit'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3) != 0,
           $urandom_range(0, 31) == 0, acc);
    end

    // Single-stage chain.
    @(negedge clk);
    in_valid1 = 1'b1; in_data1 = 8'h11; out_ready1 = 1'b0;
    #1;
    chk("s1_in_ready_empty", in_ready1, 1);
    @(posedge clk); #1;
    chk("s1_occ", occ1, 1);
    chk("s1_valid", out_valid1, 1);
    chk("s1_data", out_data1, 8'h11);
    @(negedge clk);
    in_data1 = 8'h22; out_ready1 = 1'b1;
    #1;
    chk("s1_in_ready_full_go", in_ready1, 1);
    @(posedge clk); #1;
    chk("s1_occ_swap", occ1, 1);
    chk("s1_data_swap", out_data1, 8'h22);
    @(negedge clk);
    in_data1 = 8'h33; out_ready1 = 1'b0;
    #1;
    chk("s1_in_ready_stall", in_ready1, 0);
    @(posedge clk); #1;
    chk("s1_data_hold", out_data1, 8'h22);
    in_valid1 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
